// File: rtl/wb_arbiter_pkg.sv
// Shared widths and helpers for the write-back arbiter.
// Supplies the DATA_WIDTH / RD_WIDTH / WB_NREQ defaults used as parameter defaults.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef RD_WIDTH
`define RD_WIDTH 5
`endif
`ifndef WB_NREQ
`define WB_NREQ 3
`endif

package wb_arbiter_pkg;

  localparam int SB_REGS = 32;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin successor of idx, wrapping n-1 -> 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Round-robin selector: one-hot grant to the first valid requester at or after ptr.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [2*NREQ-1:0] dbl_valid;
  logic [NREQ-1:0]   rot_valid;
  logic [NREQ-1:0]   rot_grant;
  logic [2*NREQ-1:0] dbl_grant;

  // Rotate so ptr lands at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    dbl_valid = {valid, valid};
    rot_valid = NREQ'(dbl_valid >> ptr);
    rot_grant = rot_valid & ~(rot_valid - NREQ'(1));
    dbl_grant = {rot_grant, rot_grant} << ptr;
    grant     = dbl_grant[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back port arbiter: round-robin grant, one registered RF write per cycle.
// Optional destination scoreboard compiled in when WB_SCOREBOARD_EN is defined.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = `WB_NREQ,
  parameter int DW   = `DATA_WIDTH,
  parameter int AW   = `RD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_we,
  output logic [AW-1:0]      rf_wa,
  output logic [DW-1:0]      rf_wd
`ifdef WB_SCOREBOARD_EN
  ,
  input  logic               alloc_valid,
  input  logic [AW-1:0]      alloc_rd,
  input  logic [AW-1:0]      rs1,
  input  logic [AW-1:0]      rs2,
  output logic               rs1_busy,
  output logic               rs2_busy
`endif
);

  localparam int PW = ptr_width(NREQ);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_wa_q, rf_wa_d;
  logic [DW-1:0]   rf_wd_q, rf_wd_d;

  logic [NREQ-1:0] raw_grant;
  logic [NREQ-1:0] grant;
  logic            any_gnt;
  logic [PW-1:0]   gnt_idx;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (raw_grant)
  );

  // No handshake may complete while reset is held.
  assign grant     = raw_grant & {NREQ{rst_n}};
  assign any_gnt   = |grant;
  assign req_ready = grant;

  always_comb begin
    gnt_idx  = '0;
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_idx  = PW'(i);
        sel_rd   = req_rd[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    rf_we_d = 1'b0;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (any_gnt) begin
      ptr_d   = PW'(rr_next(int'(gnt_idx), NREQ));
      rf_we_d = (sel_rd != '0);
      rf_wa_d = sel_rd;
      rf_wd_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;

`ifdef WB_SCOREBOARD_EN
  logic [SB_REGS-1:0] busy_q, busy_d;

  // Clear first so a same-cycle allocation of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (any_gnt && sel_rd != '0)
      busy_d[sel_rd] = 1'b0;
    if (alloc_valid && alloc_rd != '0)
      busy_d[alloc_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (scoreboard steps run when WB_SCOREBOARD_EN is defined).
module tb_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rf_we;
  logic [AW-1:0]      rf_wa;
  logic [DW-1:0]      rf_wd;
`ifdef WB_SCOREBOARD_EN
  logic               alloc_valid;
  logic [AW-1:0]      alloc_rd;
  logic [AW-1:0]      rs1;
  logic [AW-1:0]      rs2;
  logic               rs1_busy;
  logic               rs2_busy;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .NREQ (NREQ),
    .DW   (DW),
    .AW   (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd)
`ifdef WB_SCOREBOARD_EN
    ,
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("[TB] %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] data);
    req_rd[i*AW +: AW]   = rd;
    req_data[i*DW +: DW] = data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  logic [NREQ-1:0] rr_gnt [6];
  logic [AW-1:0]   rr_rd  [6];
  logic [DW-1:0]   rr_wd  [6];

  initial begin
    rr_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rr_rd  = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    rr_wd  = '{32'h101, 32'h102, 32'h103, 32'h101, 32'h102, 32'h103};

    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_rd    = '0;
    req_data  = '0;
`ifdef WB_SCOREBOARD_EN
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    rs1         = '0;
    rs2         = '0;
`endif

    // Reset state, with requests pending.
    #3;
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_we", 32'(rf_we), 32'h0);
    chk("reset_wa", 32'(rf_wa), 32'h0);
    chk("reset_wd", rf_wd, 32'h0);
    tick();
    chk("reset_we_after_edge", 32'(rf_we), 32'h0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Single request from requester 0.
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("single_we", 32'(rf_we), 32'h1);
    chk("single_wa", 32'(rf_wa), 32'h5);
    chk("single_wd", rf_wd, 32'hDEADBEEF);
    tick();
    chk("idle_we", 32'(rf_we), 32'h0);
    chk("idle_wa_hold", 32'(rf_wa), 32'h5);
    chk("idle_wd_hold", rf_wd, 32'hDEADBEEF);

    // Round-robin with all requesters continuously valid.
    do_reset();
    set_req(0, 5'd1, 32'h101);
    set_req(1, 5'd2, 32'h102);
    set_req(2, 5'd3, 32'h103);
    req_valid = 3'b111;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(rr_gnt[k]));
      tick();
      chk($sformatf("rr_we_%0d", k), 32'(rf_we), 32'h1);
      chk($sformatf("rr_wa_%0d", k), 32'(rf_wa), 32'(rr_rd[k]));
      chk($sformatf("rr_wd_%0d", k), rf_wd, rr_wd[k]);
    end

    // Pointer skip and wrap: ptr=0 -> grant 1, ptr=2 -> grant 2, ptr=0 -> grant 0.
    req_valid = 3'b110;
    #1;
    chk("skip_ready_a", 32'(req_ready), 32'h2);
    tick();
    req_valid = 3'b101;
    #1;
    chk("skip_ready_b", 32'(req_ready), 32'h4);
    tick();
    chk("skip_wa_b", 32'(rf_wa), 32'h3);
    chk("wrap_ready_c", 32'(req_ready), 32'h1);
    tick();
    chk("wrap_wa_c", 32'(rf_wa), 32'h1);

    // Write to x0 is accepted but suppressed.
    set_req(1, 5'd0, 32'h1234);
    req_valid = 3'b010;
    #1;
    chk("x0_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    chk("x0_we", 32'(rf_we), 32'h0);

    // Reset lands while a registered write to r7 is on the RF port.
    set_req(2, 5'd7, 32'hCAFE0007);
    req_valid = 3'b100;
    #1;
    chk("mid_ready", 32'(req_ready), 32'h4);
    tick();
    chk("mid_we_before", 32'(rf_we), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_we_reset", 32'(rf_we), 32'h0);
    chk("mid_wa_reset", 32'(rf_wa), 32'h0);
    chk("mid_wd_reset", rf_wd, 32'h0);
    chk("mid_ready_reset", 32'(req_ready), 32'h0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Leave ptr at 1, reset, then show ptr restarted at 0.
    set_req(0, 5'd4, 32'h44);
    set_req(1, 5'd6, 32'h66);
    req_valid = 3'b001;
    tick();
    chk("first_edge_we", 32'(rf_we), 32'h1);
    req_valid = '0;
    do_reset();
    req_valid = 3'b011;
    #1;
    chk("ptr_zero_after_reset", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("ptr_zero_wa", 32'(rf_wa), 32'h4);

`ifdef WB_SCOREBOARD_EN
    do_reset();
    alloc_valid = 1'b1;
    alloc_rd    = 5'd9;
    tick();
    alloc_valid = 1'b0;
    rs1 = 5'd9;
    rs2 = 5'd10;
    #1;
    chk("sb_alloc_busy", 32'(rs1_busy), 32'h1);
    chk("sb_other_free", 32'(rs2_busy), 32'h0);
    set_req(0, 5'd9, 32'h99);
    req_valid   = 3'b001;
    alloc_valid = 1'b1;
    alloc_rd    = 5'd9;
    tick();
    alloc_valid = 1'b0;
    chk("sb_same_cycle_busy", 32'(rs1_busy), 32'h1);
    tick();
    req_valid = '0;
    chk("sb_cleared", 32'(rs1_busy), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
